micro_sequencer: RTL
====================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter ADDR_W, default 5, microprogram address width; ROM depth is 2**ADDR_W.
REQ-002 Parameter NREG, default 4, number of one-hot register output-enable lines.
REQ-003 Parameter STACK_DEPTH, default 2, number of return-address stack entries.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  leaves IDLE and begins execution at address 0.
REQ-007 step_en  input  1  sequencer advance enable; 0 stalls.
REQ-008 cy_flag  input  1  ALU carry flag, used by conditional jumps.
REQ-009 z_flag  input  1  ALU zero flag, used by conditional jumps.
REQ-010 addr  output  ADDR_W  current microprogram address.
REQ-011 ceo  output  NREG  one-hot register output enable.
REQ-012 alu_code  output  3  ALU operation code, using the shared ALU encodings (ADD, SUB, ...).
REQ-013 ce, cy_ce, a_ce  output  1 each  general, carry-register and accumulator clock enables.
REQ-014 running  output  1  high in RUN state.
REQ-015 halted  output  1  high in HALT state.
REQ-016 stack_err  output  1  sticky flag set on return-stack overflow or underflow.

Function
REQ-017 States: IDLE, RUN and HALT. Transitions: IDLE->RUN on start; RUN->HALT on a HALT op or a stack error; HALT->RUN on start, which clears addr, stack pointer and stack_err.
REQ-018 Each ROM word holds ceo, alu_code, ce, cy_ce, a_ce, seq_op (3 bits) and target (ADDR_W bits).
REQ-019 ROM read is combinational from addr.
REQ-020 Control outputs equal the ROM word only when running=1 and step_en=1; otherwise they are all zero.
REQ-021 seq_op NEXT sets addr to addr+1, wrapping from 2**ADDR_W-1 to 0.
REQ-022 seq_op JMP sets addr to target.
REQ-023 seq_op JCY jumps to target if cy_flag=1, else performs NEXT.
REQ-024 seq_op JZ jumps to target if z_flag=1, else performs NEXT.
REQ-025 seq_op CALL pushes addr+1 (wrapped) and jumps to target.
REQ-026 seq_op RET pops the stacked address into addr.
REQ-027 seq_op HALT leaves addr unchanged and enters HALT.
REQ-028 CALL with the stack full enters HALT, sets stack_err and leaves the stack unchanged.
REQ-029 RET with the stack empty behaves the same way as REQ-028.
REQ-030 Each sequencing op takes effect in exactly one clock; there is no other latency from addr to control outputs.
REQ-031 With step_en=0 in RUN, addr, the stack and the state hold.
REQ-032 start asserted in RUN is ignored.
REQ-033 Flags are sampled in the same cycle as the conditional op.
REQ-034 Unused seq_op encodings behave as NEXT.

Reset
REQ-035 rst has priority over every other input, including start and step_en, and takes effect mid-program.
REQ-036 On rst: state=IDLE, addr=0, stack pointer=0, stack_err=0, running=0, halted=0, and all control outputs = 0.

Structure
REQ-037 A shared package holds the seq_op encodings, the state enum, the ALU code constants and the control-word struct typedef.
REQ-038 The microprogram ROM is a sub-module named uprog_rom, parametrised by ADDR_W and NREG, with combinational read and contents initialised from a file.
REQ-039 The return stack, state machine and address logic are inline in micro_sequencer.

Verification
REQ-040 Reset/start: rst pulse then start with ROM[0..3] = NEXT, ceo 0001/0010/0100/1000, ADD,ADD,ADD,SUB -> addr 0,1,2,3 on consecutive cycles, matching ceo/alu_code each cycle, a_ce=1 throughout.
REQ-041 Conditional jump: ROM[4]=JCY target 10; cy_flag=1 -> addr 10; repeated with cy_flag=0 -> addr 5.
REQ-042 Call/return: ROM[2]=CALL 20, ROM[20]=RET -> addr sequence 2,20,3; three nested CALLs with STACK_DEPTH=2 -> HALT, stack_err=1, halted=1.
REQ-043 Stall/wrap: addr=31 with NEXT and step_en=0 for 3 cycles -> addr holds 31 and outputs are 0; step_en=1 -> addr 0.
REQ-044 Reset mid-operation: rst at addr 7 with a stacked entry -> next cycle addr=0, IDLE, all outputs 0; a subsequent RET at program start underflows -> stack_err=1.
REQ-045 Halt/restart: HALT op at addr 6 -> addr holds 6 and halted=1; start -> addr 0, running=1, stack_err=0.

Source files
------------

// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the micro-sequencer: sequencing op encodings,
// FSM state enum, ALU operation codes and the per-word control struct.
// A ROM word is laid out as {ceo[NREG], ctrl_t, target[ADDR_W]}, MSB first.
package micro_sequencer_pkg;

  // Sequencing ops; encoding 3'd7 is unused and executes as NEXT.
  typedef enum logic [2:0] {
    SEQ_NEXT = 3'd0,
    SEQ_JMP  = 3'd1,
    SEQ_JCY  = 3'd2,
    SEQ_JZ   = 3'd3,
    SEQ_CALL = 3'd4,
    SEQ_RET  = 3'd5,
    SEQ_HALT = 3'd6
  } seq_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // ALU operation codes shared with the datapath.
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_INC  = 3'd5;
  localparam logic [2:0] ALU_DEC  = 3'd6;
  localparam logic [2:0] ALU_PASS = 3'd7;

  // Width-independent middle section of a ROM word.
  typedef struct packed {
    logic [2:0] alu_code;
    logic       ce;
    logic       cy_ce;
    logic       a_ce;
    seq_op_e    seq_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // Total ROM word width for a given address width and register count.
  function automatic int rom_word_w(input int addr_w, input int nreg);
    return nreg + CTRL_W + addr_w;
  endfunction

endpackage

// File: rtl/uprog_rom.sv
// Microprogram ROM with combinational read.
// The image arrives through INIT, which the build generates from the
// microprogram source file; word i occupies INIT[i*WORD_W +: WORD_W].
// Ports:
//   addr_i   - microprogram address
//   ceo_o    - register output-enable field of the addressed word
//   ctrl_o   - ALU code, clock enables and seq_op of the addressed word
//   target_o - jump/call target of the addressed word
module uprog_rom
  import micro_sequencer_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int NREG   = 4,
  parameter logic [(2**ADDR_W)*(NREG+CTRL_W+ADDR_W)-1:0] INIT = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [NREG-1:0]   ceo_o,
  output ctrl_t             ctrl_o,
  output logic [ADDR_W-1:0] target_o
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int WORD_W = rom_word_w(ADDR_W, NREG);

  logic [WORD_W-1:0] rom [DEPTH];
  logic [WORD_W-1:0] word;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign rom[i] = INIT[i*WORD_W +: WORD_W];
  end

  assign word = rom[addr_i];
  assign {ceo_o, ctrl_o, target_o} = word;

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: IDLE/RUN/HALT state machine, address register,
// return-address stack and gating of the ROM control word.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   start_i               - begin execution at address 0 from IDLE or HALT
//   step_en_i             - advance enable; low stalls the sequencer
//   cy_flag_i, z_flag_i   - ALU flags tested by JCY / JZ
//   addr_o                - current microprogram address
//   ceo_o                 - one-hot register output enable
//   alu_code_o            - ALU operation code
//   ce_o, cy_ce_o, a_ce_o - general, carry and accumulator clock enables
//   running_o, halted_o   - RUN / HALT state indicators
//   stack_err_o           - sticky return-stack overflow/underflow flag
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int NREG        = 4,
  parameter int STACK_DEPTH = 2,
  parameter logic [(2**ADDR_W)*(NREG+CTRL_W+ADDR_W)-1:0] ROM_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              step_en_i,
  input  logic              cy_flag_i,
  input  logic              z_flag_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [NREG-1:0]   ceo_o,
  output logic [2:0]        alu_code_o,
  output logic              ce_o,
  output logic              cy_ce_o,
  output logic              a_ce_o,
  output logic              running_o,
  output logic              halted_o,
  output logic              stack_err_o
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [NREG-1:0]   rom_ceo;
  ctrl_t             rom_ctrl;
  logic [ADDR_W-1:0] rom_target;

  logic [ADDR_W-1:0] addr_inc;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic              push_en;
  logic              active;

  uprog_rom #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG),
    .INIT   (ROM_INIT)
  ) u_rom (
    .addr_i   (addr_q),
    .ceo_o    (rom_ceo),
    .ctrl_o   (rom_ctrl),
    .target_o (rom_target)
  );

  // Natural overflow gives the wrap from the last address back to 0.
  assign addr_inc = addr_q + ADDR_W'(1);
  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_i) begin
          state_d = ST_RUN;
          addr_d  = '0;
          sp_d    = '0;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (step_en_i) begin
          case (rom_ctrl.seq_op)
            SEQ_JMP: addr_d = rom_target;
            SEQ_JCY: addr_d = cy_flag_i ? rom_target : addr_inc;
            SEQ_JZ:  addr_d = z_flag_i  ? rom_target : addr_inc;
            SEQ_CALL: begin
              if (sp_q == SP_FULL) begin
                state_d = ST_HALT;
                err_d   = 1'b1;
              end else begin
                push_en = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                addr_d  = rom_target;
              end
            end
            SEQ_RET: begin
              if (sp_q == '0) begin
                state_d = ST_HALT;
                err_d   = 1'b1;
              end else begin
                sp_d   = sp_q - SP_W'(1);
                addr_d = stack_q[pop_idx];
              end
            end
            SEQ_HALT: state_d = ST_HALT;
            default:  addr_d  = addr_inc;  // NEXT and unused encodings
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // NOTE: stack storage is deliberately not reset; sp_q alone defines which
  // entries are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (!rst && push_en) begin
      stack_q[push_idx] <= addr_inc;
    end
  end

  assign running_o   = (state_q == ST_RUN);
  assign halted_o    = (state_q == ST_HALT);
  assign stack_err_o = err_q;
  assign addr_o      = addr_q;

  // Control word reaches the datapath only on an executing cycle.
  assign active     = running_o && step_en_i;
  assign ceo_o      = active ? rom_ceo           : '0;
  assign alu_code_o = active ? rom_ctrl.alu_code : '0;
  assign ce_o       = active && rom_ctrl.ce;
  assign cy_ce_o    = active && rom_ctrl.cy_ce;
  assign a_ce_o     = active && rom_ctrl.a_ce;

endmodule
